// File: rtl/shift_pkg.sv
// Shared constants for the universal shift register: operation encodings
// and the per-bit next-value select used by each register stage.
package shift_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'b001;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'b011;
  localparam logic [MODE_W-1:0] MODE_ROR  = 3'b100;
  localparam logic [MODE_W-1:0] MODE_ROL  = 3'b101;

  // UPPER takes the bit from index i+1 (rightward move), LOWER from index i-1.
  typedef enum logic [1:0] {
    SEL_HOLD  = 2'b00,
    SEL_UPPER = 2'b01,
    SEL_LOWER = 2'b10,
    SEL_LOAD  = 2'b11
  } stage_sel_e;

endpackage

// File: rtl/shift_stage.sv
// One bit of the shift register: a flop with synchronous reset value and a
// four-way next-value mux.
module shift_stage
  import shift_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rst_val,
  input  stage_sel_e sel,
  input  logic       from_upper,
  input  logic       from_lower,
  input  logic       load_bit,
  output logic       q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= rst_val;
    end else begin
      case (sel)
        SEL_UPPER: q <= from_upper;
        SEL_LOWER: q <= from_lower;
        SEL_LOAD:  q <= load_bit;
        default:   q <= q;
      endcase
    end
  end

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register: hold/shift/rotate/load datapath built from
// per-bit stages, plus a saturating shift counter with a one-shot DONE pulse.
module universal_shift_register
  import shift_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       EN,
  input  logic [MODE_W-1:0]          MODE,
  input  logic                       SIN_R,
  input  logic                       SIN_L,
  input  logic [WIDTH-1:0]           PIN,
  output logic [WIDTH-1:0]           POUT,
  output logic                       SOUT_R,
  output logic                       SOUT_L,
  output logic [$clog2(WIDTH+1)-1:0] CNT,
  output logic                       DONE
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] from_upper;
  logic [WIDTH-1:0] from_lower;
  stage_sel_e       sel;
  logic             is_shift;
  logic             is_load;

  // Reserved encodings and EN=0 fall through to hold with no count activity.
  always_comb begin
    sel      = SEL_HOLD;
    is_shift = 1'b0;
    is_load  = 1'b0;
    if (EN) begin
      case (MODE)
        MODE_SHR, MODE_ROR: begin
          sel      = SEL_UPPER;
          is_shift = 1'b1;
        end
        MODE_SHL, MODE_ROL: begin
          sel      = SEL_LOWER;
          is_shift = 1'b1;
        end
        MODE_LOAD: begin
          sel     = SEL_LOAD;
          is_load = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Edge bits choose between the serial input and the wrap-around bit.
  assign from_upper = {(MODE == MODE_ROR) ? q[0] : SIN_R, q[WIDTH-1:1]};
  assign from_lower = {q[WIDTH-2:0], (MODE == MODE_ROL) ? q[WIDTH-1] : SIN_L};

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    shift_stage u_stage (
      .clk        (CLK),
      .rst        (RST),
      .rst_val    (RST_VAL[i]),
      .sel        (sel),
      .from_upper (from_upper[i]),
      .from_lower (from_lower[i]),
      .load_bit   (PIN[i]),
      .q          (q[i])
    );
  end

  // DONE fires only on the WIDTH-1 -> WIDTH step; saturation keeps it from re-firing.
  always_ff @(posedge CLK) begin
    if (RST) begin
      CNT  <= '0;
      DONE <= 1'b0;
    end else if (is_load) begin
      CNT  <= '0;
      DONE <= 1'b0;
    end else if (is_shift && (CNT != CNT_MAX)) begin
      CNT  <= CNT + 1'b1;
      DONE <= (CNT == CNT_LAST);
    end else begin
      DONE <= 1'b0;
    end
  end

  assign POUT   = q;
  assign SOUT_R = q[0];
  assign SOUT_L = q[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register at WIDTH=4: a vector table
// through a scoreboard queue, then a modelled rotate/saturation sequence.
module tb_universal_shift_register;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic [2:0]   mode = 3'b000;
  logic         sin_r = 1'b0;
  logic         sin_l = 1'b0;
  logic [W-1:0] pin = '0;
  logic [W-1:0] pout;
  logic         sout_r;
  logic         sout_l;
  logic [2:0]   cnt;
  logic         done;

  int tests  = 0;
  int errors = 0;

  typedef struct {
    logic         en;
    logic         rst;
    logic [2:0]   mode;
    logic         sin_r;
    logic         sin_l;
    logic [W-1:0] pin;
    logic [W-1:0] pout;
    logic [2:0]   cnt;
    logic         done;
    string        name;
  } vec_t;

  typedef struct {
    logic [W-1:0] pout;
    logic [2:0]   cnt;
    logic         done;
    string        name;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  universal_shift_register #(.WIDTH(W), .RST_VAL(4'b0000)) dut (
    .CLK    (clk),
    .RST    (rst),
    .EN     (en),
    .MODE   (mode),
    .SIN_R  (sin_r),
    .SIN_L  (sin_l),
    .PIN    (pin),
    .POUT   (pout),
    .SOUT_R (sout_r),
    .SOUT_L (sout_l),
    .CNT    (cnt),
    .DONE   (done)
  );

  always #5 clk = ~clk;

  task automatic compare(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    tests++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, req);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (exp_q.size() == 0) begin
      tests++;
      errors++;
      $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
      return;
    end
    e = exp_q.pop_front();
    compare({e.name, " pout"}, pout, e.pout);
    compare({e.name, " cnt"}, W'(cnt), W'(e.cnt));
    compare({e.name, " done"}, W'(done), W'(e.done));
    compare({e.name, " sout_r"}, W'(sout_r), W'(e.pout[0]));
    compare({e.name, " sout_l"}, W'(sout_l), W'(e.pout[W-1]));
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    en    = v.en;
    rst   = v.rst;
    mode  = v.mode;
    sin_r = v.sin_r;
    sin_l = v.sin_l;
    pin   = v.pin;
    exp_q.push_back('{v.pout, v.cnt, v.done, v.name});
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    logic [W-1:0] m_q;
    logic [2:0]   m_cnt;
    logic         m_done;

    //            en   rst  mode    sr   sl   pin      pout     cnt  done
    vecs.push_back('{1'b1,1'b1,3'b000,1'b0,1'b0,4'b0000,4'b0000,3'd0,1'b0,"reset"});
    vecs.push_back('{1'b1,1'b0,3'b011,1'b0,1'b0,4'b1011,4'b1011,3'd0,1'b0,"load1011"});
    vecs.push_back('{1'b1,1'b0,3'b001,1'b0,1'b0,4'b0000,4'b0101,3'd1,1'b0,"shr1"});
    vecs.push_back('{1'b1,1'b0,3'b001,1'b0,1'b0,4'b0000,4'b0010,3'd2,1'b0,"shr2"});
    vecs.push_back('{1'b1,1'b0,3'b001,1'b0,1'b0,4'b0000,4'b0001,3'd3,1'b0,"shr3"});
    vecs.push_back('{1'b1,1'b0,3'b001,1'b0,1'b0,4'b0000,4'b0000,3'd4,1'b1,"shr4"});
    vecs.push_back('{1'b1,1'b0,3'b000,1'b0,1'b0,4'b0000,4'b0000,3'd4,1'b0,"hold_after_done"});
    vecs.push_back('{1'b1,1'b0,3'b001,1'b1,1'b0,4'b0000,4'b1000,3'd4,1'b0,"shr_saturated"});
    vecs.push_back('{1'b1,1'b0,3'b011,1'b0,1'b0,4'b1000,4'b1000,3'd0,1'b0,"load1000"});
    vecs.push_back('{1'b1,1'b0,3'b101,1'b0,1'b0,4'b0000,4'b0001,3'd1,1'b0,"rol1"});
    vecs.push_back('{1'b1,1'b0,3'b101,1'b0,1'b0,4'b0000,4'b0010,3'd2,1'b0,"rol2"});
    vecs.push_back('{1'b1,1'b0,3'b101,1'b0,1'b0,4'b0000,4'b0100,3'd3,1'b0,"rol3"});
    vecs.push_back('{1'b1,1'b0,3'b101,1'b0,1'b0,4'b0000,4'b1000,3'd4,1'b1,"rol4"});
    vecs.push_back('{1'b1,1'b0,3'b101,1'b0,1'b0,4'b0000,4'b0001,3'd4,1'b0,"rol5"});
    vecs.push_back('{1'b1,1'b0,3'b011,1'b0,1'b0,4'b0110,4'b0110,3'd0,1'b0,"load0110"});
    vecs.push_back('{1'b1,1'b0,3'b010,1'b0,1'b1,4'b0000,4'b1101,3'd1,1'b0,"shl_en1"});
    vecs.push_back('{1'b0,1'b0,3'b010,1'b0,1'b1,4'b0000,4'b1101,3'd1,1'b0,"shl_en0"});
    vecs.push_back('{1'b1,1'b0,3'b010,1'b0,1'b1,4'b0000,4'b1011,3'd2,1'b0,"shl_en1b"});
    vecs.push_back('{1'b1,1'b0,3'b011,1'b0,1'b0,4'b1100,4'b1100,3'd0,1'b0,"load1100"});
    vecs.push_back('{1'b1,1'b0,3'b100,1'b0,1'b0,4'b0000,4'b0110,3'd1,1'b0,"mix_ror1"});
    vecs.push_back('{1'b1,1'b0,3'b100,1'b0,1'b0,4'b0000,4'b0011,3'd2,1'b0,"mix_ror2"});
    vecs.push_back('{1'b1,1'b0,3'b001,1'b1,1'b0,4'b0000,4'b1001,3'd3,1'b0,"mix_shr"});
    vecs.push_back('{1'b1,1'b0,3'b010,1'b0,1'b0,4'b0000,4'b0010,3'd4,1'b1,"mix_shl"});
    vecs.push_back('{1'b1,1'b0,3'b011,1'b0,1'b0,4'b1111,4'b1111,3'd0,1'b0,"load1111"});
    vecs.push_back('{1'b1,1'b0,3'b001,1'b0,1'b0,4'b0000,4'b0111,3'd1,1'b0,"rst_seq_shr1"});
    vecs.push_back('{1'b1,1'b0,3'b001,1'b0,1'b0,4'b0000,4'b0011,3'd2,1'b0,"rst_seq_shr2"});
    vecs.push_back('{1'b1,1'b0,3'b001,1'b0,1'b0,4'b0000,4'b0001,3'd3,1'b0,"rst_seq_shr3"});
    vecs.push_back('{1'b1,1'b1,3'b001,1'b0,1'b0,4'b0000,4'b0000,3'd0,1'b0,"rst_with_shr4"});
    vecs.push_back('{1'b1,1'b0,3'b000,1'b0,1'b0,4'b0000,4'b0000,3'd0,1'b0,"no_done_after_rst"});
    vecs.push_back('{1'b1,1'b0,3'b011,1'b0,1'b0,4'b1010,4'b1010,3'd0,1'b0,"load1010"});
    vecs.push_back('{1'b1,1'b0,3'b110,1'b1,1'b1,4'b0000,4'b1010,3'd0,1'b0,"reserved110a"});
    vecs.push_back('{1'b1,1'b0,3'b111,1'b1,1'b1,4'b0000,4'b1010,3'd0,1'b0,"reserved111"});
    vecs.push_back('{1'b1,1'b0,3'b110,1'b1,1'b1,4'b0000,4'b1010,3'd0,1'b0,"reserved110b"});
    vecs.push_back('{1'b1,1'b0,3'b001,1'b0,1'b0,4'b0000,4'b0101,3'd1,1'b0,"race_shr1"});
    vecs.push_back('{1'b1,1'b0,3'b001,1'b0,1'b0,4'b0000,4'b0010,3'd2,1'b0,"race_shr2"});
    vecs.push_back('{1'b1,1'b0,3'b001,1'b0,1'b0,4'b0000,4'b0001,3'd3,1'b0,"race_shr3"});
    vecs.push_back('{1'b1,1'b0,3'b011,1'b0,1'b0,4'b0110,4'b0110,3'd0,1'b0,"race_load"});
    vecs.push_back('{1'b1,1'b0,3'b000,1'b0,1'b0,4'b0000,4'b0110,3'd0,1'b0,"race_after"});
    vecs.push_back('{1'b0,1'b1,3'b101,1'b0,1'b0,4'b0000,4'b0000,3'd0,1'b0,"rst_with_en0"});
    vecs.push_back('{1'b0,1'b0,3'b011,1'b0,1'b0,4'b1111,4'b0000,3'd0,1'b0,"load_en0"});

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
    end

    // Rotate past saturation, checked against an independent model.
    applyStimulus('{1'b1,1'b0,3'b011,1'b0,1'b0,4'b0001,4'b0001,3'd0,1'b0,"model_load"});
    m_q   = 4'b0001;
    m_cnt = 3'd0;
    for (int k = 0; k < 7; k++) begin
      m_done = (m_cnt == 3'd3);
      m_q    = {m_q[0], m_q[W-1:1]};
      if (m_cnt < 3'd4) m_cnt = m_cnt + 3'd1;
      applyStimulus('{1'b1,1'b0,3'b100,1'b0,1'b0,4'b0000,m_q,m_cnt,m_done,$sformatf("model_ror%0d", k)});
    end

    if (exp_q.size() != 0) begin
      tests++;
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/universal_shift_register.md
UNIVERSAL_SHIFT_REGISTER -- requirements
Module: universal_shift_register

Interface
REQ-001 Parameter WIDTH, default 8, register length in bits; legal range 2..64.
REQ-002 Parameter RST_VAL, default 0 (WIDTH bits), register contents after reset.
REQ-003 Port CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 Port RST  input  1  reset; synchronous and active-high.
REQ-005 Port EN  input  1  clock enable; when low, all state holds.
REQ-006 Port MODE  input  3  operation select, encodings in REQ-012.
REQ-007 Port SIN_R  input  1  serial input for right shift; enters bit WIDTH-1.
REQ-008 Port SIN_L  input  1  serial input for left shift; enters bit 0.
REQ-009 Port PIN  input  WIDTH  parallel load data.
REQ-010 Port POUT  output  WIDTH  register contents Q.
REQ-011 Ports SOUT_R, SOUT_L, CNT, DONE:
- SOUT_R  output  1  = Q[0], combinational from Q.
- SOUT_L  output  1  = Q[WIDTH-1], combinational from Q.
- CNT  output  clog2(WIDTH+1)  shifts completed since last LOAD or reset, saturating.
- DONE  output  1  registered one-cycle pulse marking shift-count completion.

Function
REQ-012 MODE SHALL decode as follows; each action applies only on an edge with EN=1 and RST=0:
- 000 HOLD: Q <= Q.
- 001 SHR: Q <= {SIN_R, Q[WIDTH-1:1]}.
- 010 SHL: Q <= {Q[WIDTH-2:0], SIN_L}.
- 011 LOAD: Q <= PIN.
- 100 ROR: Q <= {Q[0], Q[WIDTH-1:1]}.
- 101 ROL: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}.
- 110, 111 reserved: behave exactly as HOLD, including counter.
REQ-013 Latency SHALL be one clock: POUT reflects an operation on the edge that samples it; SOUT_R/SOUT_L follow POUT with no additional delay.
REQ-014 LOAD SHALL clear CNT to 0 and force DONE to 0 on the same edge.
REQ-015 Each SHR, SHL, ROR or ROL with EN=1 SHALL increment CNT by 1, saturating at WIDTH.
REQ-016 DONE SHALL be 1 for exactly the one cycle following the edge on which CNT goes from WIDTH-1 to WIDTH; it SHALL be 0 at all other times.
REQ-017 Once CNT=WIDTH, further shifts SHALL leave CNT at WIDTH and SHALL NOT re-pulse DONE until a LOAD or reset re-arms it.
REQ-018 HOLD, reserved modes and EN=0 SHALL leave Q and CNT unchanged and SHALL drive DONE 0 on that edge.
REQ-019 A LOAD issued on the edge where DONE would otherwise assert SHALL win: CNT=0, DONE=0.
REQ-020 Mixed shift directions SHALL count alike; the counter tracks operations performed, not bit positions.

Reset
REQ-021 On an edge with RST=1, Q SHALL become RST_VAL, CNT SHALL become 0 and DONE SHALL become 0, regardless of EN and MODE.
REQ-022 Reset asserted mid-sequence SHALL abandon the count; no DONE pulse SHALL follow.
REQ-023 No output SHALL depend on RST combinationally.

Structure
REQ-024 Mode encodings (HOLD, SHR, SHL, LOAD, ROR, ROL) SHALL be named constants in shared package shift_pkg, with the MODE width constant.
REQ-025 Per-bit datapath SHALL be sub-module shift_stage, instantiated WIDTH times via generate:
- one flop with synchronous reset value;
- a next-value mux selecting hold, left neighbour, right neighbour or load bit.
REQ-026 Edge-bit neighbour selection (serial input vs. wrap) and the counter/DONE logic SHALL live in the top module.

Verification (WIDTH=4, RST_VAL=0)
REQ-027 Reset then LOAD PIN=1011 -> POUT=1011, CNT=0, DONE=0.
REQ-028 From 1011, four SHR with SIN_R=0 -> POUT 0101, 0010, 0001, 0000; SOUT_R sequence 1,1,0,1 read before each shift; DONE=1 only in the cycle after the 4th shift; CNT=4.
REQ-029 LOAD 1000, then ROL x4 -> POUT 0001, 0010, 0100, 1000; DONE pulses once; a 5th ROL gives 0001 with CNT=4 and DONE=0.
REQ-030 LOAD 0110, then SHL SIN_L=1 with EN toggling 1,0,1 -> POUT 1101, 1101, 1011; CNT 1, 1, 2.
REQ-031 After three SHR from LOAD, assert RST together with a 4th SHR -> POUT=0000, CNT=0, no DONE pulse.
REQ-032 MODE=110/111 for 3 cycles after LOAD 1010 -> POUT=1010, CNT=0; then 3 SHR plus a LOAD on the 4th edge -> CNT=0, DONE never asserted.
